// File: rtl/wb_irq_vic_slave.sv
// Wishbone pipelined vectored interrupt controller with edge-detected sources.
// Optional software trigger register is built when VIC_SW_IRQ_EN is defined.
module wb_irq_vic_slave #(
  parameter int NUM_IRQS    = 8,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_i,
  input  logic [2:0]          wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic                wb_stall_o,
  input  logic [NUM_IRQS-1:0] irqs_i,
  output logic                irq_master_o
);

  localparam int HW = $clog2(HOLDOFF_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_HOLDOFF
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_IRQS-1:0] irqs_q, pending, imr;
  logic [NUM_IRQS-1:0] edge_hit, sw_set, eoi_clr, act;
  logic [NUM_IRQS-1:0] wdat;
  logic [1:0]          ctl;
  logic [4:0]          vec, vec_nxt, win;
  logic [HW-1:0]       hold, hold_nxt;
  logic                acc, wr, eoi;
  logic [31:0]         rd_data;
  logic                unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_dat_i};
  assign wb_stall_o  = 1'b0;

  assign acc  = wb_cyc_i & wb_stb_i;
  assign wr   = acc & wb_we_i;
  assign wdat = wb_dat_i[NUM_IRQS-1:0];
  assign eoi  = wr && (wb_adr_i == 3'd7)
                   && (state == S_ASSERT);
  assign act  = pending & imr;

  assign edge_hit = ctl[1] ? (irqs_i & ~irqs_q)
                           : (~irqs_i & irqs_q);

`ifdef VIC_SW_IRQ_EN
  assign sw_set = (wr && wb_adr_i == 3'd6) ? wdat : '0;
`else
  assign sw_set = '0;
`endif

  always_comb begin
    eoi_clr = '0;
    for (int i = 0; i < NUM_IRQS; i++)
      eoi_clr[i] = eoi && (vec == 5'(i));
  end

  // Scan downward so the lowest active index wins
  always_comb begin
    win = '0;
    for (int i = NUM_IRQS - 1; i >= 0; i--)
      if (act[i]) win = 5'(i);
  end

  always_comb begin
    rd_data = '0;
    unique case (wb_adr_i)
      3'd0:    rd_data[1:0]          = ctl;
      3'd3:    rd_data[NUM_IRQS-1:0] = imr;
      3'd4:    rd_data[4:0]          = vec;
      3'd5:    rd_data[NUM_IRQS-1:0] = pending;
      default: rd_data               = '0;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ctl      <= '0;
      imr      <= '0;
      pending  <= '0;
      irqs_q   <= '0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= (acc && !wb_we_i) ? rd_data : '0;
      irqs_q   <= irqs_i;
      // Set terms are ORed last so a new event beats the EOI clear
      pending  <= (pending & ~eoi_clr) | edge_hit | sw_set;
      if (wr) begin
        unique case (wb_adr_i)
          3'd0:    ctl <= wb_dat_i[1:0];
          3'd1:    imr <= imr | wdat;
          3'd2:    imr <= imr & ~wdat;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state <= S_IDLE;
      vec   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      vec   <= vec_nxt;
      hold  <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    hold_nxt  = hold;
    unique case (state)
      S_IDLE: begin
        if (ctl[0] && |act) begin
          vec_nxt   = win;
          state_nxt = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (eoi) begin
          vec_nxt   = '0;
          hold_nxt  = HW'(HOLDOFF_CYC);
          state_nxt = S_HOLDOFF;
        end else if (!ctl[0]) begin
          vec_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      S_HOLDOFF: begin
        if (hold == '0) state_nxt = S_IDLE;
        else            hold_nxt  = hold - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign irq_master_o = (state == S_ASSERT);

endmodule

// File: tb/tb_wb_irq_vic_slave.sv
// Directed bench for wb_irq_vic_slave.
// Expectations for the SWIR register follow VIC_SW_IRQ_EN.
module tb_wb_irq_vic_slave;

  localparam int N  = 8;
  localparam int HO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic        ack, stall, irq;
  logic [N-1:0] irqs;

  int nvec = 0;
  int nmis = 0;

  wb_irq_vic_slave #(
    .NUM_IRQS    (N),
    .HOLDOFF_CYC (HO)
  ) dut (
    .clk_sys_i    (clk),
    .rst_sys_i    (rst),
    .wb_adr_i     (adr),
    .wb_dat_i     (wdat),
    .wb_dat_o     (rdat),
    .wb_cyc_i     (cyc),
    .wb_stb_i     (stb),
    .wb_we_i      (we),
    .wb_sel_i     (sel),
    .wb_ack_o     (ack),
    .wb_stall_o   (stall),
    .irqs_i       (irqs),
    .irq_master_o (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc = 1; stb = 1; we = 1; adr = a; wdat = d;
    tick(1);
    chk("wr_ack", 32'(ack), 1);
    cyc = 0; stb = 0; we = 0; wdat = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a,
                    input logic [31:0] exp);
    cyc = 1; stb = 1; we = 0; adr = a;
    tick(1);
    chk({tag, "_ack"}, 32'(ack), 1);
    chk(tag, rdat, exp);
    cyc = 0; stb = 0;
  endtask

  task automatic wait_irq(input string tag, input int max,
                          output int n);
    n = 0;
    while (!irq && n < max) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(irq), 1);
  endtask

  int n;
  int hi;

  initial begin
    rst = 1; cyc = 1; stb = 1; we = 0; adr = '0;
    wdat = '0; sel = 4'hf; irqs = '0;
    @(posedge clk); #1;
    chk("rst_no_ack", 32'(ack), 0);
    tick(2);
    rst = 0; cyc = 0; stb = 0;
    tick(1);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dat", rdat, 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_stall", 32'(stall), 0);
    rd("rst_ctl", 3'd0, 0);
    rd("rst_imr", 3'd3, 0);
    rd("rst_risr", 3'd5, 0);

    // Single rising source, latency N+2
    wr(3'd1, 32'h1);
    wr(3'd0, 32'h3);
    rd("ctl", 3'd0, 32'h3);
    irqs[0] = 1'b1;
    tick(1);
    chk("lat_n1", 32'(irq), 0);
    tick(1);
    chk("lat_n2", 32'(irq), 1);
    rd("var0", 3'd4, 0);
    rd("risr0", 3'd5, 32'h1);

    wr(3'd7, 32'h0);
    chk("eoi_drop", 32'(irq), 0);
    hi = 0;
    for (int i = 0; i < HO; i++) begin
      if (irq) hi++;
      tick(1);
    end
    chk("holdoff_low", 32'(hi), 0);
    rd("risr_eoi", 3'd5, 0);

    // Back-to-back: IER write then IMR read
    cyc = 1; stb = 1; we = 1; adr = 3'd1; wdat = 32'hFF;
    tick(1);
    chk("b2b_ack0", 32'(ack), 1);
    we = 0; adr = 3'd3;
    tick(1);
    chk("b2b_ack1", 32'(ack), 1);
    chk("b2b_imr", rdat, 32'hFF);
    cyc = 0; stb = 0;

    // Two simultaneous edges: lowest index first
    irqs = 8'h25;
    wait_irq("irq_p2", 10, n);
    rd("var2", 3'd4, 32'd2);
    rd("risr25", 3'd5, 32'h24);
    wr(3'd7, 32'h0);
    wait_irq("irq_p5", 3 * HO, n);
    chk("holdoff_len", 32'(n > HO), 1);
    rd("var5", 3'd4, 32'd5);
    rd("risr5", 3'd5, 32'h20);
    wr(3'd7, 32'h0);
    tick(HO + 4);
    chk("idle_noirq", 32'(irq), 0);

    // New edge on in-service line during EOI
    irqs = 8'h2D;
    wait_irq("irq_p3", 10, n);
    rd("var3", 3'd4, 32'd3);
    irqs[3] = 1'b0;
    tick(1);
    irqs[3] = 1'b1;
    wr(3'd7, 32'h0);
    rd("risr3_kept", 3'd5, 32'h08);
    wait_irq("irq_p3_again", 3 * HO, n);
    rd("var3_again", 3'd4, 32'd3);
    wr(3'd7, 32'h0);
    rd("risr_clr3", 3'd5, 0);

    // Falling polarity, only line 0 unmasked
    irqs = '0;
    tick(1);
    wr(3'd2, 32'hFE);
    rd("imr01", 3'd3, 32'h01);
    wr(3'd0, 32'h1);
    rd("risr_polchg", 3'd5, 0);
    irqs[0] = 1'b1;
    tick(2);
    rd("risr_rise_ign", 3'd5, 0);
    irqs[0] = 1'b0;
    tick(2);
    rd("risr_fall", 3'd5, 32'h1);
    wait_irq("irq_fall", 3 * HO, n);

    // Disable while asserted
    wr(3'd0, 32'h0);
    tick(1);
    chk("dis_drop", 32'(irq), 0);
    rd("dis_pend", 3'd5, 32'h1);
    wr(3'd0, 32'h1);
    wait_irq("reen_irq", 10, n);

    // Masking the in-service line keeps irq up
    wr(3'd2, 32'h01);
    tick(2);
    chk("idr_hold", 32'(irq), 1);
    wr(3'd7, 32'h0);
    chk("idr_eoi", 32'(irq), 0);
    rd("idr_risr", 3'd5, 0);

    // Software trigger and register readback
    wr(3'd6, 32'h1);
`ifdef VIC_SW_IRQ_EN
    rd("swir_risr", 3'd5, 32'h1);
`else
    rd("swir_risr", 3'd5, 0);
`endif
    rd("swir_rd", 3'd6, 0);
    rd("eoir_rd", 3'd7, 0);

    // Reset mid-transfer
    cyc = 1; stb = 1; we = 0; adr = 3'd0; rst = 1;
    tick(1);
    chk("rst_mid_ack", 32'(ack), 0);
    cyc = 0; stb = 0; rst = 0;
    rd("rst_mid_ctl", 3'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
